// File: rtl/operand_mem_loader.sv
// Streams NUM_WORDS operand words into a single-port RAM, then reads them back
// and compares an XOR checksum of the readback against the written stream.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module operand_mem_loader #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_WORDS  = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  done,
    output logic                  check_ok
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_WORD    = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] VERIFY_END   = CW'(NUM_WORDS + 1);
    localparam logic [CW-1:0] FIRST_SAMPLE = CW'(2);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         counter, counter_next;
    logic [DATA_WIDTH-1:0] wr_sum, wr_sum_next;
    logic [DATA_WIDTH-1:0] rd_sum, rd_sum_next;
    logic                  check_ok_next;
    logic                  transfer;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            wr_sum   <= '0;
            rd_sum   <= '0;
            check_ok <= 1'b0;
        end else begin
            state    <= state_next;
            counter  <= counter_next;
            wr_sum   <= wr_sum_next;
            rd_sum   <= rd_sum_next;
            check_ok <= check_ok_next;
        end
    end

    // The counter doubles as write address in LOAD and as read address and
    // cycle index in VERIFY; reads return two cycles after issue.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        wr_sum_next   = wr_sum;
        rd_sum_next   = rd_sum;
        check_ok_next = check_ok;
        in_ready      = 1'b0;
        mem_wren      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        transfer      = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next    = LOAD;
                    counter_next  = '0;
                    wr_sum_next   = '0;
                    rd_sum_next   = '0;
                    check_ok_next = 1'b0;
                end
            end
            LOAD: begin
                in_ready = ~reset;
                transfer = in_valid & ~reset;
                mem_wren = transfer;
                if (transfer) begin
                    wr_sum_next = wr_sum ^ in_data;
                    if (counter == LAST_WORD) begin
                        state_next   = VERIFY;
                        counter_next = '0;
                    end else begin
                        counter_next = counter + 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (counter >= FIRST_SAMPLE) begin
                    rd_sum_next = rd_sum ^ mem_q;
                end
                if (counter == VERIFY_END) begin
                    state_next    = DONE;
                    counter_next  = '0;
                    check_ok_next = ((rd_sum ^ mem_q) == wr_sum);
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_address = counter[ADDR_WIDTH-1:0];
    assign mem_data    = in_data;

endmodule

// File: tb/tb_operand_mem_loader.sv
// Scoreboard bench for operand_mem_loader: a 4-word instance (full address
// space) and a 1-word instance, each driving a registered-output RAM model.

module tb_operand_mem_loader;

    localparam int DW = 8;

    typedef struct {
        int addr;
        int data;
    } wr_exp_t;

    typedef struct {
        int cyc;
        int ok;
    } done_exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic          start_4, in_valid_4, in_ready_4, mem_wren_4, busy_4, done_4, check_ok_4;
    logic [DW-1:0] in_data_4, mem_data_4, mem_q_4;
    logic [1:0]    mem_address_4;
    logic          start_1, in_valid_1, in_ready_1, mem_wren_1, busy_1, done_1, check_ok_1;
    logic [DW-1:0] in_data_1, mem_data_1, mem_q_1;
    logic [0:0]    mem_address_1;

    logic [DW-1:0] ram_4 [4];
    logic [1:0]    raddr_4;
    logic [DW-1:0] ram_1 [2];
    logic [0:0]    raddr_1;
    logic          corrupt_4 = 1'b0;

    wr_exp_t   wq_4[$];
    wr_exp_t   wq_1[$];
    done_exp_t dq_4[$];
    done_exp_t dq_1[$];

    operand_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .NUM_WORDS(4)) dut4 (
        .clock(clock), .reset(reset), .start(start_4), .in_valid(in_valid_4),
        .in_data(in_data_4), .in_ready(in_ready_4), .mem_address(mem_address_4),
        .mem_data(mem_data_4), .mem_wren(mem_wren_4), .mem_q(mem_q_4),
        .busy(busy_4), .done(done_4), .check_ok(check_ok_4)
    );

    operand_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .NUM_WORDS(1)) dut1 (
        .clock(clock), .reset(reset), .start(start_1), .in_valid(in_valid_1),
        .in_data(in_data_1), .in_ready(in_ready_1), .mem_address(mem_address_1),
        .mem_data(mem_data_1), .mem_wren(mem_wren_1), .mem_q(mem_q_1),
        .busy(busy_1), .done(done_1), .check_ok(check_ok_1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM models: registered address plus registered output gives 2-cycle reads.
    always @(posedge clock) begin
        if (mem_wren_4) ram_4[mem_address_4] <= mem_data_4;
        raddr_4 <= mem_address_4;
        mem_q_4 <= (corrupt_4 && raddr_4 == 2'd2) ? 8'hFF : ram_4[raddr_4];
        if (mem_wren_1) ram_1[mem_address_1] <= mem_data_1;
        raddr_1 <= mem_address_1;
        mem_q_1 <= ram_1[raddr_1];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT writes or signals done.
    always @(negedge clock) begin
        wr_exp_t   w;
        done_exp_t d;
        if (mem_wren_4) begin
            checkOutput("write4_expected", int'(wq_4.size() != 0), 1);
            if (wq_4.size() != 0) begin
                w = wq_4.pop_front();
                checkOutput("write4_addr", int'(mem_address_4), w.addr);
                checkOutput("write4_data", int'(mem_data_4), w.data);
            end
        end
        if (mem_wren_1) begin
            checkOutput("write1_expected", int'(wq_1.size() != 0), 1);
            if (wq_1.size() != 0) begin
                w = wq_1.pop_front();
                checkOutput("write1_addr", int'(mem_address_1), w.addr);
                checkOutput("write1_data", int'(mem_data_1), w.data);
            end
        end
        if (done_4) begin
            checkOutput("done4_expected", int'(dq_4.size() != 0), 1);
            if (dq_4.size() != 0) begin
                d = dq_4.pop_front();
                checkOutput("done4_cycle", cyc, d.cyc);
                checkOutput("done4_check_ok", int'(check_ok_4), d.ok);
            end
        end
        if (done_1) begin
            checkOutput("done1_expected", int'(dq_1.size() != 0), 1);
            if (dq_1.size() != 0) begin
                d = dq_1.pop_front();
                checkOutput("done1_cycle", cyc, d.cyc);
                checkOutput("done1_check_ok", int'(check_ok_1), d.ok);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic v, input logic [DW-1:0] d);
        if (sel == 4) begin
            start_4 = s; in_valid_4 = v; in_data_4 = d;
        end else begin
            start_1 = s; in_valid_1 = v; in_data_1 = d;
        end
    endtask

    function automatic int sel_out(input int sel, input logic a4, input logic a1);
        return (sel == 4) ? int'(a4) : int'(a1);
    endfunction

    // One full load: words[8*i +: 8] is word i; optional stall after word
    // gap_after; poke holds in_valid and pulses start in VERIFY and DONE.
    task automatic applyStimulus(input int sel, input int n, input logic [31:0] words,
                                 input int gap_after, input int gap_len, input bit poke,
                                 input int exp_ok, input int exp_lat);
        done_exp_t     e;
        wr_exp_t       w;
        logic [DW-1:0] word;
        bit            got;
        e.cyc = cyc + exp_lat - 1;
        e.ok  = exp_ok;
        if (sel == 4) dq_4.push_back(e); else dq_1.push_back(e);
        drive(sel, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("busy_in_load", sel_out(sel, busy_4, busy_1), 1);
        checkOutput("in_ready_in_load", sel_out(sel, in_ready_4, in_ready_1), 1);
        checkOutput("check_ok_cleared", sel_out(sel, check_ok_4, check_ok_1), 0);
        for (int i = 0; i < n; i++) begin
            word   = words[8*i +: 8];
            w.addr = i;
            w.data = int'(word);
            if (sel == 4) wq_4.push_back(w); else wq_1.push_back(w);
            drive(sel, 1'b0, 1'b1, word);
            tick();
            if (i == gap_after) begin
                drive(sel, 1'b0, 1'b0, 8'h5A);
                repeat (gap_len) tick();
            end
        end
        if (poke) drive(sel, 1'b1, 1'b1, 8'hEE);
        else      drive(sel, 1'b0, 1'b0, 8'h00);
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            tick();
            if (poke) drive(sel, 1'b0, 1'b1, 8'hEE);
            if (sel_out(sel, done_4, done_1) != 0) begin
                got = 1'b1;
                if (poke) drive(sel, 1'b1, 1'b1, 8'hEE);
            end
        end
        checkOutput("done_seen", int'(got), 1);
        tick();
        drive(sel, 1'b0, 1'b0, 8'h00);
        checkOutput("check_ok_held", sel_out(sel, check_ok_4, check_ok_1), exp_ok);
        if (poke) begin
            repeat (3) begin
                tick();
                checkOutput("no_restart", sel_out(sel, busy_4, busy_1), 0);
            end
        end
        repeat (2) tick();
    endtask

    initial begin
        wr_exp_t w;
        reset = 1'b1;
        drive(4, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        repeat (2) tick();
        checkOutput("reset_busy", int'(busy_4), 0);
        checkOutput("reset_in_ready", int'(in_ready_4), 0);
        checkOutput("reset_done", int'(done_4), 0);
        checkOutput("reset_check_ok", int'(check_ok_4), 0);
        checkOutput("reset_wren", int'(mem_wren_4), 0);
        checkOutput("reset_address", int'(mem_address_4), 0);
        reset = 1'b0;
        tick();

        $display("[TB] continuous load 1,2,3,4");
        applyStimulus(4, 4, 32'h04030201, -1, 0, 1'b0, 1, 12);

        $display("[TB] load with 3-cycle stall between words 2 and 3");
        applyStimulus(4, 4, 32'h04030201, 1, 3, 1'b0, 1, 15);

        $display("[TB] readback corrupted at address 2");
        corrupt_4 = 1'b1;
        applyStimulus(4, 4, 32'h04030201, -1, 0, 1'b0, 0, 12);
        corrupt_4 = 1'b0;

        $display("[TB] reset during load after 2 words");
        drive(4, 1'b1, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 2; i++) begin
            w.addr = i;
            w.data = 16 * (i + 1);
            wq_4.push_back(w);
            drive(4, 1'b0, 1'b1, 8'(w.data));
            tick();
        end
        drive(4, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(4, 1'b0, 1'b1, 8'h77);
        checkOutput("abort_busy", int'(busy_4), 0);
        checkOutput("abort_in_ready", int'(in_ready_4), 0);
        checkOutput("abort_wren", int'(mem_wren_4), 0);
        checkOutput("abort_address", int'(mem_address_4), 0);
        tick();
        drive(4, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(4, 4, 32'h08070605, -1, 0, 1'b0, 1, 12);

        $display("[TB] start pulsed in VERIFY and DONE with in_valid held");
        applyStimulus(4, 4, 32'h0C0B0A09, -1, 0, 1'b1, 1, 12);

        $display("[TB] single-word load 0xA5");
        applyStimulus(1, 1, 32'h000000A5, -1, 0, 1'b0, 1, 6);

        checkOutput("write4_queue_drained", wq_4.size(), 0);
        checkOutput("done4_queue_drained", dq_4.size(), 0);
        checkOutput("write1_queue_drained", wq_1.size(), 0);
        checkOutput("done1_queue_drained", dq_1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
